// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch/jump flush,
// multi-cycle EX sequencing (RUN/BUSY), operand forwarding and a
// saturating count of stalled cycles.
module hazard_ctrl #(
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16,
  parameter int FWD_EN = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IFID_Rs_i,
  input  logic [4:0]       IFID_Rt_i,
  input  logic [4:0]       IDEX_Rs_i,
  input  logic [4:0]       IDEX_Rt_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       EXMEM_Rd_i,
  input  logic             EXMEM_RegWrite_i,
  input  logic [4:0]       MEMWB_Rd_i,
  input  logic             MEMWB_RegWrite_i,
  input  logic             Branch_taken_i,
  input  logic             Jump_i,
  input  logic             MC_start_i,
  output logic             PC_Write_o,
  output logic             IFID_Write_o,
  output logic             IDEX_Write_o,
  output logic             IFID_Flush_o,
  output logic             IDEX_Bubble_o,
  output logic             EXMEM_Bubble_o,
  output logic [1:0]       ForwardA_o,
  output logic [1:0]       ForwardB_o,
  output logic             MC_busy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int MCW = $clog2(MC_LAT) + 1;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [MCW-1:0]   mc_cnt_q, mc_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             load_use_s;
  logic             mc_go_s;

  assign load_use_s = IDEX_MemRead_i && (IDEX_Rt_i != 5'd0) &&
                      ((IDEX_Rt_i == IFID_Rs_i) || (IDEX_Rt_i == IFID_Rt_i));

  // A multi-cycle op may only launch from an undisturbed RUN cycle.
  assign mc_go_s = (state_q == ST_RUN) && MC_start_i && (MC_LAT > 1) &&
                   !Branch_taken_i && !Jump_i && !load_use_s;

  // Stage control outputs; reset forces a flushed, frozen pipeline.
  always_comb begin
    PC_Write_o     = 1'b1;
    IFID_Write_o   = 1'b1;
    IDEX_Write_o   = 1'b1;
    IFID_Flush_o   = 1'b0;
    IDEX_Bubble_o  = 1'b0;
    EXMEM_Bubble_o = 1'b0;
    MC_busy_o      = 1'b0;
    if (!rst_i) begin
      PC_Write_o    = 1'b0;
      IFID_Write_o  = 1'b0;
      IDEX_Write_o  = 1'b0;
      IFID_Flush_o  = 1'b1;
      IDEX_Bubble_o = 1'b1;
    end else if (state_q == ST_BUSY) begin
      PC_Write_o     = 1'b0;
      IFID_Write_o   = 1'b0;
      IDEX_Write_o   = 1'b0;
      EXMEM_Bubble_o = 1'b1;
      MC_busy_o      = 1'b1;
    end else if (Branch_taken_i) begin
      IFID_Flush_o  = 1'b1;
      IDEX_Bubble_o = 1'b1;
    end else if (load_use_s) begin
      PC_Write_o    = 1'b0;
      IFID_Write_o  = 1'b0;
      IDEX_Bubble_o = 1'b1;
    end else if (Jump_i) begin
      IFID_Flush_o = 1'b1;
    end else begin
      PC_Write_o = 1'b1;
    end
  end

  // Operand forwarding: the younger EX/MEM result wins over MEM/WB.
  always_comb begin
    ForwardA_o = 2'b00;
    ForwardB_o = 2'b00;
    if ((FWD_EN != 0) && rst_i) begin
      if (EXMEM_RegWrite_i && (EXMEM_Rd_i != 5'd0) && (EXMEM_Rd_i == IDEX_Rs_i)) begin
        ForwardA_o = 2'b10;
      end else if (MEMWB_RegWrite_i && (MEMWB_Rd_i != 5'd0) && (MEMWB_Rd_i == IDEX_Rs_i)) begin
        ForwardA_o = 2'b01;
      end else begin
        ForwardA_o = 2'b00;
      end
      if (EXMEM_RegWrite_i && (EXMEM_Rd_i != 5'd0) && (EXMEM_Rd_i == IDEX_Rt_i)) begin
        ForwardB_o = 2'b10;
      end else if (MEMWB_RegWrite_i && (MEMWB_Rd_i != 5'd0) && (MEMWB_Rd_i == IDEX_Rt_i)) begin
        ForwardB_o = 2'b01;
      end else begin
        ForwardB_o = 2'b00;
      end
    end else begin
      ForwardA_o = 2'b00;
      ForwardB_o = 2'b00;
    end
  end

  // RUN/BUSY next-state and multi-cycle down-counter.
  always_comb begin
    state_d  = state_q;
    mc_cnt_d = mc_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (mc_go_s) begin
          state_d  = ST_BUSY;
          mc_cnt_d = MCW'(MC_LAT - 1);
        end else begin
          state_d  = ST_RUN;
          mc_cnt_d = {MCW{1'b0}};
        end
      end
      ST_BUSY: begin
        if (mc_cnt_q == MCW'(1)) begin
          state_d  = ST_RUN;
          mc_cnt_d = {MCW{1'b0}};
        end else begin
          state_d  = ST_BUSY;
          mc_cnt_d = mc_cnt_q - MCW'(1);
        end
      end
      default: begin
        state_d  = ST_RUN;
        mc_cnt_d = {MCW{1'b0}};
      end
    endcase
  end

  // Saturating count of cycles in which the PC was held.
  always_comb begin
    if (!PC_Write_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers; reset aborts any multi-cycle op in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_RUN;
      mc_cnt_q    <= {MCW{1'b0}};
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      mc_cnt_q    <= mc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MC_LAT, default 4, SHALL set the EX latency in cycles of a multi-cycle op; legal range 1..16.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the stall-cycle counter.
REQ-003 Parameter FWD_EN, default 1, SHALL enable forwarding; when 0, ForwardA_o and ForwardB_o SHALL be tied to 00.
REQ-004 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-005 clk_i  in  1  clock, rising edge.
REQ-006 rst_i  in  1  asynchronous reset, active-low.
REQ-007 IFID_Rs_i, IFID_Rt_i  in  5 each  source registers of the instruction in ID.
REQ-008 IDEX_Rs_i, IDEX_Rt_i  in  5 each  source registers of the instruction in EX.
REQ-009 IDEX_Rt_i also serves as the load destination; IDEX_MemRead_i  in  1  the instruction in EX is a load.
REQ-010 EXMEM_Rd_i  in  5, EXMEM_RegWrite_i  in  1  MEM-stage destination and write enable.
REQ-011 MEMWB_Rd_i  in  5, MEMWB_RegWrite_i  in  1  WB-stage destination and write enable.
REQ-012 Branch_taken_i  in  1  branch resolved taken in EX; Jump_i  in  1  jump decoded in ID.
REQ-013 MC_start_i  in  1  the instruction in ID is a multi-cycle op.
REQ-014 PC_Write_o, IFID_Write_o, IDEX_Write_o  out  1 each  stage write enables.
REQ-015 IFID_Flush_o, IDEX_Bubble_o, EXMEM_Bubble_o  out  1 each  insert a NOP into the named register.
REQ-016 ForwardA_o, ForwardB_o  out  2 each  operand select: 00 register file, 10 EX/MEM, 01 MEM/WB.
REQ-017 MC_busy_o  out  1  FSM is in BUSY; stall_cnt_o  out  CNT_W  saturating count of stalled cycles.

Function
REQ-018 The FSM SHALL have two states, RUN and BUSY, plus a down-counter mc_cnt of width clog2(MC_LAT)+1.
REQ-019 RUN -> BUSY SHALL occur at the clock edge ending a RUN cycle in which MC_start_i=1, MC_LAT>1, no flush and no load-use stall; mc_cnt SHALL load MC_LAT-1.
REQ-020 In BUSY, mc_cnt SHALL decrement each cycle; BUSY -> RUN SHALL occur at the edge where mc_cnt=1.
REQ-021 With MC_LAT=1, BUSY SHALL never be entered.
REQ-022 In BUSY: PC_Write_o=0, IFID_Write_o=0, IDEX_Write_o=0, EXMEM_Bubble_o=1, MC_busy_o=1; Branch_taken_i, Jump_i and MC_start_i SHALL be ignored.
REQ-023 Load-use in RUN: IDEX_MemRead_i=1, IDEX_Rt_i!=0, and IDEX_Rt_i equals IFID_Rs_i or IFID_Rt_i.
REQ-024 A load-use hit SHALL give PC_Write_o=0, IFID_Write_o=0, IDEX_Bubble_o=1 for that cycle only.
REQ-025 Branch_taken_i=1 in RUN SHALL give IFID_Flush_o=1 and IDEX_Bubble_o=1, with PC_Write_o=1, and SHALL override any load-use stall or MC_start_i in the same cycle.
REQ-026 Jump_i=1 in RUN without Branch_taken_i SHALL give IFID_Flush_o=1 only.
REQ-027 Priority SHALL be: BUSY > branch flush > load-use stall > jump flush.
REQ-028 In RUN with no condition active, outputs SHALL be: all Write_o=1, all Flush/Bubble_o=0, MC_busy_o=0.
REQ-029 ForwardA_o SHALL be 10 when EXMEM_RegWrite_i=1, EXMEM_Rd_i!=0 and EXMEM_Rd_i=IDEX_Rs_i.
REQ-030 Otherwise ForwardA_o SHALL be 01 when MEMWB_RegWrite_i=1, MEMWB_Rd_i!=0 and MEMWB_Rd_i=IDEX_Rs_i; otherwise 00. ForwardB_o SHALL use the same rules with IDEX_Rt_i.
REQ-031 Forwarding SHALL be combinational and independent of FSM state.
REQ-032 stall_cnt_o SHALL increment at each edge ending a cycle with PC_Write_o=0, saturating at 2^CNT_W-1.

Reset
REQ-033 While rst_i=0: state=RUN, mc_cnt=0, stall_cnt_o=0, all Write_o=0, IFID_Flush_o=1, IDEX_Bubble_o=1, EXMEM_Bubble_o=0, Forward*_o=00, MC_busy_o=0.
REQ-034 Reset asserted in BUSY SHALL abort the op immediately; the first cycle after release SHALL be RUN.

Verification
REQ-035 Load-use: IDEX_MemRead_i=1, IDEX_Rt_i=8, IFID_Rs_i=8 -> exactly one cycle PC_Write_o=0, IDEX_Bubble_o=1; stall_cnt_o increments by 1.
REQ-036 MC op with MC_LAT=4: MC_start_i pulse at cycle T -> MC_busy_o=1 in cycles T+1..T+3, RUN at T+4; stall_cnt_o increments by 3.
REQ-037 Forwarding: EXMEM_Rd_i=MEMWB_Rd_i=IDEX_Rs_i=5, both RegWrite=1 -> ForwardA_o=10; with EXMEM_Rd_i=0 -> ForwardA_o=01.
REQ-038 Branch_taken_i=1 together with a load-use hit -> IFID_Flush_o=1, IDEX_Bubble_o=1, PC_Write_o=1; stall_cnt_o unchanged.
REQ-039 rst_i low during BUSY (second cycle) -> MC_busy_o=0 immediately, stall_cnt_o=0, RUN outputs after release.
REQ-040 With CNT_W=4, hold load-use for 20 cycles -> stall_cnt_o saturates at 15.
